// File: rtl/wdt_ctrl_regs.sv
// Watchdog register front-end: CPU register port, two-key kick sequence, lock,
// sticky interrupt status and escalation to a system reset request.
module wdt_ctrl_regs #(
  parameter int unsigned      WD_CNT_W = 16,
  parameter int unsigned      ESC_W    = 16,
  parameter logic [ESC_W-1:0] ESC_RST  = ESC_W'(8'hFF),
  parameter logic [15:0]      KEY1     = 16'h5555,
  parameter logic [15:0]      KEY2     = 16'hAAAA
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr,
  input  logic                i_rd,
  input  logic [2:0]          i_addr,
  input  logic [31:0]         i_wdata,
  output logic [31:0]         o_rdata,
  output logic                o_rvalid,
  output logic                o_wd_en,
  output logic                o_wd_clear,
  output logic [WD_CNT_W-1:0] o_wd_val,
  input  logic                i_wd_irq,
  output logic                o_irq,
  output logic                o_sys_rst_req
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LOAD   = 3'd1;
  localparam logic [2:0] A_KICK   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_ESC    = 3'd4;

  typedef enum logic {K_IDLE, K_K1} kick_t;
  typedef enum logic [1:0] {ESC_IDLE, ESC_ARMED, ESC_FIRE} esc_t;

  kick_t               kick_q, kick_n;
  esc_t                esc_q, esc_n;
  logic                en_q, en_n, irq_en_q, irq_en_n, rst_en_q, rst_en_n, lock_q, lock_n;
  logic [WD_CNT_W-1:0] load_q, load_n;
  logic [ESC_W-1:0]    esc_reg_q, esc_reg_n, cnt_q, cnt_n;
  logic                pend_q, pend_n, kerr_q, kerr_n, escd_q, escd_n;
  logic                irq_prev_q, irq_rise;
  logic                clear_q, clear_n, key_err_set;
  logic                irq_q, rst_req_q, rvalid_q;
  logic [31:0]         rdata_q, rdata_c;
  logic [2:0]          w1c;
  logic                unused_wdata;

  assign unused_wdata  = ^i_wdata;
  assign irq_rise      = i_wd_irq & ~irq_prev_q;
  assign o_rdata       = rdata_q;
  assign o_rvalid      = rvalid_q;
  assign o_wd_en       = en_q;
  assign o_wd_clear    = clear_q;
  assign o_wd_val      = load_q;
  assign o_irq         = irq_q;
  assign o_sys_rst_req = rst_req_q;

  // Configuration registers; frozen while LOCK is set.
  always_comb begin
    en_n      = en_q;
    irq_en_n  = irq_en_q;
    rst_en_n  = rst_en_q;
    lock_n    = lock_q;
    load_n    = load_q;
    esc_reg_n = esc_reg_q;
    if (i_wr && !lock_q) begin
      case (i_addr)
        A_CTRL: begin
          en_n     = i_wdata[0];
          irq_en_n = i_wdata[1];
          rst_en_n = i_wdata[2];
          lock_n   = i_wdata[31];
        end
        A_LOAD:  load_n    = i_wdata[WD_CNT_W-1:0];
        A_ESC:   esc_reg_n = i_wdata[ESC_W-1:0];
        default: ;
      endcase
    end
  end

  // Kick key sequence.
  always_comb begin
    kick_n      = kick_q;
    clear_n     = 1'b0;
    key_err_set = 1'b0;
    if (i_wr) begin
      case (kick_q)
        K_IDLE: begin
          if (i_addr == A_KICK) begin
            if (i_wdata[15:0] == KEY1) kick_n = K_K1;
            else                       key_err_set = 1'b1;
          end
        end
        K_K1: begin
          kick_n = K_IDLE;
          if (i_addr == A_KICK && i_wdata[15:0] == KEY2) clear_n = 1'b1;
          else                                           key_err_set = 1'b1;
        end
        default: kick_n = K_IDLE;
      endcase
    end
  end

  // Escalation: a pending kick pulse beats both arming and expiry.
  always_comb begin
    esc_n = esc_q;
    cnt_n = cnt_q;
    case (esc_q)
      ESC_IDLE: begin
        if (irq_rise && en_q && rst_en_q && !clear_q) begin
          esc_n = ESC_ARMED;
          cnt_n = esc_reg_q;
        end
      end
      ESC_ARMED: begin
        if (clear_q || !en_q || !rst_en_q) esc_n = ESC_IDLE;
        else if (cnt_q == '0)              esc_n = ESC_FIRE;
        else                               cnt_n = cnt_q - ESC_W'(1);
      end
      ESC_FIRE: esc_n = ESC_FIRE;
      default:  esc_n = ESC_IDLE;
    endcase
  end

  // Sticky status with write-1-to-clear; a same-cycle set wins.
  always_comb begin
    w1c    = (i_wr && i_addr == A_STATUS) ? i_wdata[2:0] : 3'b000;
    pend_n = (pend_q & ~w1c[0]) | irq_rise;
    kerr_n = (kerr_q & ~w1c[1]) | key_err_set;
    escd_n = (escd_q & ~w1c[2]) | (esc_n == ESC_FIRE);
  end

  always_comb begin
    rdata_c = '0;
    case (i_addr)
      A_CTRL:   rdata_c = {lock_q, 28'b0, rst_en_q, irq_en_q, en_q};
      A_LOAD:   rdata_c = 32'(load_q);
      A_STATUS: rdata_c = {29'b0, escd_q, kerr_q, pend_q};
      A_ESC:    rdata_c = 32'(esc_reg_q);
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      kick_q     <= K_IDLE;
      esc_q      <= ESC_IDLE;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      rst_en_q   <= 1'b0;
      lock_q     <= 1'b0;
      load_q     <= '1;
      esc_reg_q  <= ESC_RST;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      kerr_q     <= 1'b0;
      escd_q     <= 1'b0;
      irq_prev_q <= 1'b0;
      clear_q    <= 1'b0;
      irq_q      <= 1'b0;
      rst_req_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      kick_q     <= kick_n;
      esc_q      <= esc_n;
      en_q       <= en_n;
      irq_en_q   <= irq_en_n;
      rst_en_q   <= rst_en_n;
      lock_q     <= lock_n;
      load_q     <= load_n;
      esc_reg_q  <= esc_reg_n;
      cnt_q      <= cnt_n;
      pend_q     <= pend_n;
      kerr_q     <= kerr_n;
      escd_q     <= escd_n;
      irq_prev_q <= i_wd_irq;
      clear_q    <= clear_n;
      irq_q      <= pend_n & irq_en_n;
      rst_req_q  <= (esc_n == ESC_FIRE);
      rvalid_q   <= i_rd;
      rdata_q    <= i_rd ? rdata_c : '0;
    end
  end

endmodule
